// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic-phase sequencer: phase encoding,
// per-approach light codes and the phase-duration lookup.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_GREEN  = 3'd0,
    ST_EXTEND = 3'd1,
    ST_YELLOW = 3'd2,
    ST_ALLRED = 3'd3,
    ST_WALK   = 3'd4,
    ST_FLASH  = 3'd5
  } state_e;

  // Per-approach lamp codes, {red, yellow, green}
  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_OFF    = 3'b000;

  // Duration in ticks of the phase being entered. FLASH is untimed (it leaves on a
  // tick with flash_mode low), so it just gets the minimum value.
  function automatic int unsigned phase_dur(
    input state_e      st,
    input int unsigned green_t,
    input int unsigned ext_t,
    input int unsigned yellow_t,
    input int unsigned allred_t,
    input int unsigned walk_t
  );
    int unsigned d;
    case (st)
      ST_GREEN:  d = green_t;
      ST_EXTEND: d = ext_t;
      ST_YELLOW: d = yellow_t;
      ST_ALLRED: d = allred_t;
      ST_WALK:   d = walk_t;
      default:   d = 1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-driven phase down-counter. The count is loaded with DUR-1 on phase entry;
// a tick seen while the count is already zero is the expiry and is flagged
// combinationally so the owning FSM can move on that same edge.
module phase_timer #(
  parameter int unsigned         CNT_W   = 8,
  parameter logic [CNT_W-1:0]    RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             tick_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  assign done_o = tick_i && (cnt_q == '0);

  // Load has priority over counting; the count holds at zero until the expiring tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/light_phase_sequencer.sv
// N-approach traffic-phase sequencer. Rotates green across approaches with one
// optional sensor extension per green, yellow, all-red clearance, a latched
// pedestrian walk phase and a flashing-red fail-safe. Lamp outputs are decoded
// from the registered state one cycle later.
//
//  state  | meaning
//  GREEN  | approach cur green, base duration
//  EXTEND | approach cur green, single extension granted at GREEN expiry
//  YELLOW | approach cur yellow
//  ALLRED | clearance, every approach red
//  WALK   | pedestrian walk, every approach red
//  FLASH  | fail-safe, all reds blink on each tick
module light_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned N_APPR   = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GREEN_T  = 6,
  parameter int unsigned EXT_T    = 3,
  parameter int unsigned YELLOW_T = 2,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned WALK_T   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [N_APPR-1:0]     sensor,
  input  logic                  walk_req,
  input  logic                  flash_mode,
  output logic [3*N_APPR-1:0]   lights,
  output logic                  walk_light,
  output logic [N_APPR-1:0]     active
);

  localparam int unsigned CUR_W = (N_APPR > 1) ? $clog2(N_APPR) : 1;
  localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(N_APPR - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);

  state_e             state_q, state_d;
  logic [CUR_W-1:0]   cur_q, cur_d, cur_next;
  logic               walk_pend_q, walk_pend_d;
  logic               flash_ph_q, flash_ph_d;
  logic               tmr_load;
  logic               tmr_done;
  logic               walk_entry;
  logic [CNT_W-1:0]   tmr_val;

  logic [3*N_APPR-1:0] lights_q, lights_d;
  logic                walk_light_q, walk_light_d;
  logic [N_APPR-1:0]   active_q, active_d;

  assign cur_next = (cur_q == CUR_LAST) ? '0 : cur_q + 1'b1;
  assign tmr_val  = CNT_W'(phase_dur(state_d, GREEN_T, EXT_T, YELLOW_T, ALLRED_T, WALK_T) - 1);

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .tick_i  (tick),
    .done_o  (tmr_done)
  );

  // Next-phase selection: fail-safe entry beats a coincident expiry
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    flash_ph_d = flash_ph_q;
    tmr_load   = 1'b0;
    walk_entry = 1'b0;
    if ((state_q != ST_FLASH) && flash_mode) begin
      state_d    = ST_FLASH;
      flash_ph_d = 1'b1;
      tmr_load   = 1'b1;
    end else if (state_q == ST_FLASH) begin
      if (tick) begin
        if (!flash_mode) begin
          // Park on the last approach so approach 0 is the next green
          state_d  = ST_ALLRED;
          cur_d    = CUR_LAST;
          tmr_load = 1'b1;
        end else begin
          flash_ph_d = ~flash_ph_q;
        end
      end
    end else if (tmr_done) begin
      tmr_load = 1'b1;
      case (state_q)
        ST_GREEN:  state_d = sensor[cur_q] ? ST_EXTEND : ST_YELLOW;
        ST_EXTEND: state_d = ST_YELLOW;
        ST_YELLOW: state_d = ST_ALLRED;
        ST_ALLRED: begin
          if (walk_pend_q) begin
            state_d    = ST_WALK;
            walk_entry = 1'b1;
          end else begin
            state_d = ST_GREEN;
            cur_d   = cur_next;
          end
        end
        ST_WALK: begin
          state_d = ST_GREEN;
          cur_d   = cur_next;
        end
        default: state_d = ST_ALLRED;
      endcase
    end
  end

  // A request on the walk-entry edge is dropped: the clear wins
  assign walk_pend_d = walk_entry ? 1'b0 : (walk_pend_q | walk_req);

  // Phase, approach index, walk latch and flash phase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ALLRED;
      cur_q       <= CUR_LAST;
      walk_pend_q <= 1'b0;
      flash_ph_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      walk_pend_q <= walk_pend_d;
      flash_ph_q  <= flash_ph_d;
    end
  end

  // Lamp decode from the registered phase; only approach cur may be non-red
  always_comb begin
    lights_d     = '0;
    active_d     = '0;
    walk_light_d = (state_q == ST_WALK);
    for (int i = 0; i < N_APPR; i++) begin
      active_d[i] = (CUR_W'(i) == cur_q);
      case (state_q)
        ST_GREEN, ST_EXTEND: lights_d[3*i +: 3] = active_d[i] ? LT_GREEN : LT_RED;
        ST_YELLOW:           lights_d[3*i +: 3] = active_d[i] ? LT_YELLOW : LT_RED;
        ST_FLASH:            lights_d[3*i +: 3] = flash_ph_q ? LT_RED : LT_OFF;
        default:             lights_d[3*i +: 3] = LT_RED;
      endcase
    end
  end

  // Output registers, one cycle behind the phase register
  always_ff @(posedge clk) begin
    if (rst) begin
      lights_q     <= {N_APPR{LT_RED}};
      walk_light_q <= 1'b0;
      active_q     <= N_APPR'(1) << (N_APPR - 1);
    end else begin
      lights_q     <= lights_d;
      walk_light_q <= walk_light_d;
      active_q     <= active_d;
    end
  end

  assign lights     = lights_q;
  assign walk_light = walk_light_q;
  assign active     = active_q;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Scoreboard bench: two sequencers (2 and 3 approaches) share one randomized
// stimulus stream. A tick-counting phase model predicts each cycle's outputs,
// which are queued and checked by an independent monitor.
module tb_light_phase_sequencer;

  localparam int GREEN_T  = 6;
  localparam int EXT_T    = 3;
  localparam int YELLOW_T = 2;
  localparam int ALLRED_T = 1;
  localparam int WALK_T   = 3;
  localparam int NCYC     = 6000;

  localparam int P_GREEN  = 0;
  localparam int P_EXTEND = 1;
  localparam int P_YELLOW = 2;
  localparam int P_ALLRED = 3;
  localparam int P_WALK   = 4;
  localparam int P_FLASH  = 5;

  typedef struct {
    int ph;
    int cur;
    int left;   // ticks still to come in this phase, including the expiring one
    bit pend;
    bit fph;
  } mdl_t;

  typedef struct packed {
    logic [8:0] lights;
    logic       walk;
    logic [2:0] active;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, walk_req, flash_mode;
  logic [2:0] sensor;
  logic [5:0] lights2;
  logic       walk2;
  logic [1:0] act2;
  logic [8:0] lights3;
  logic       walk3;
  logic [2:0] act3;

  exp_t q2[$];
  exp_t q3[$];
  int   total = 0;
  int   bad   = 0;

  light_phase_sequencer #(.N_APPR(2)) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .sensor(sensor[1:0]), .walk_req(walk_req),
    .flash_mode(flash_mode), .lights(lights2), .walk_light(walk2), .active(act2));

  light_phase_sequencer #(.N_APPR(3)) u_dut3 (
    .clk(clk), .rst(rst), .tick(tick), .sensor(sensor), .walk_req(walk_req),
    .flash_mode(flash_mode), .lights(lights3), .walk_light(walk3), .active(act3));

  function automatic mdl_t reset_state(int n);
    mdl_t r;
    r.ph = P_ALLRED; r.cur = n - 1; r.left = ALLRED_T; r.pend = 1'b0; r.fph = 1'b0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t s, int n, bit rs, bit tk, logic [2:0] sen, bit wr, bit fl);
    mdl_t r;
    bit   went_walk;
    r = s;
    went_walk = 1'b0;
    if (rs) return reset_state(n);
    if (s.ph != P_FLASH && fl) begin
      r.ph = P_FLASH; r.fph = 1'b1;
    end else if (s.ph == P_FLASH) begin
      if (tk) begin
        if (!fl) begin
          r.ph = P_ALLRED; r.cur = n - 1; r.left = ALLRED_T;
        end else begin
          r.fph = !s.fph;
        end
      end
    end else if (tk) begin
      if (s.left > 1) begin
        r.left = s.left - 1;
      end else begin
        case (s.ph)
          P_GREEN: begin
            if (sen[s.cur]) begin r.ph = P_EXTEND; r.left = EXT_T; end
            else begin r.ph = P_YELLOW; r.left = YELLOW_T; end
          end
          P_EXTEND: begin r.ph = P_YELLOW; r.left = YELLOW_T; end
          P_YELLOW: begin r.ph = P_ALLRED; r.left = ALLRED_T; end
          P_ALLRED: begin
            if (s.pend) begin r.ph = P_WALK; r.left = WALK_T; went_walk = 1'b1; end
            else begin r.ph = P_GREEN; r.left = GREEN_T; r.cur = (s.cur + 1) % n; end
          end
          default: begin r.ph = P_GREEN; r.left = GREEN_T; r.cur = (s.cur + 1) % n; end
        endcase
      end
    end
    r.pend = went_walk ? 1'b0 : (s.pend | wr);
    return r;
  endfunction

  function automatic exp_t decode(mdl_t s, int n);
    exp_t       e;
    logic [2:0] c;
    e.lights = '0;
    e.active = '0;
    e.walk   = (s.ph == P_WALK);
    for (int i = 0; i < n; i++) begin
      c = 3'b100;
      if (s.ph == P_FLASH) c = {s.fph, 2'b00};
      else if (i == s.cur && (s.ph == P_GREEN || s.ph == P_EXTEND)) c = 3'b001;
      else if (i == s.cur && s.ph == P_YELLOW) c = 3'b010;
      e.lights[3*i +: 3] = c;
      e.active[i] = (i == s.cur);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Stimulus and model: inputs change on the falling edge
  initial begin
    mdl_t m2, m3;
    exp_t e2, e3;
    m2 = reset_state(2);
    m3 = reset_state(3);
    rst = 1'b1; tick = 1'b0; sensor = '0; walk_req = 1'b0; flash_mode = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc > 0) @(negedge clk);
      rst      = (cyc < 3) || (cyc == 1900) || (cyc >= 1600 && $urandom_range(0, 499) == 0);
      walk_req = 1'b0;
      if (cyc < 600) begin
        tick = (cyc % 4 == 0); sensor = '0; flash_mode = 1'b0;
      end else if (cyc < 1000) begin
        tick = (cyc % 4 == 0); sensor = 3'b001; flash_mode = 1'b0;
        walk_req = (cyc == 700 || cyc == 880);
      end else if (cyc < 1600) begin
        tick = (cyc % 4 == 0); sensor = 3'b101;
        flash_mode = (cyc >= 1150 && cyc < 1300);
        walk_req = (cyc == 1450);
      end else begin
        tick = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) == 0) sensor = 3'($urandom);
        walk_req = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 199) == 0) flash_mode = !flash_mode;
      end
      e2 = rst ? decode(reset_state(2), 2) : decode(m2, 2);
      e3 = rst ? decode(reset_state(3), 3) : decode(m3, 3);
      q2.push_back(e2);
      q3.push_back(e3);
      m2 = step(m2, 2, rst, tick, sensor, walk_req, flash_mode);
      m3 = step(m3, 3, rst, tick, sensor, walk_req, flash_mode);
    end
    @(posedge clk);
    #3;
    chk("queue2_drained", q2.size(), 0);
    chk("queue3_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: outputs are presented every cycle; compare just after the edge
  initial begin
    exp_t e;
    int   nonred;
    forever begin
      @(posedge clk);
      #1;
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("lights_n2", {26'd0, lights2}, {26'd0, e.lights[5:0]});
        chk("walk_n2", {31'd0, walk2}, {31'd0, e.walk});
        chk("active_n2", {30'd0, act2}, {30'd0, e.active[1:0]});
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("lights_n3", {23'd0, lights3}, {23'd0, e.lights});
        chk("walk_n3", {31'd0, walk3}, {31'd0, e.walk});
        chk("active_n3", {29'd0, act3}, {29'd0, e.active});
        nonred = 0;
        for (int i = 0; i < 3; i++) if (lights3[3*i +: 2] != 2'b00) nonred++;
        chk("one_nonred_n3", {31'd0, (nonred <= 1)}, 32'd1);
        chk("walk_all_red_n3", {31'd0, (!walk3 || lights3 == 9'b100100100)}, 32'd1);
      end
    end
  end

endmodule
